// File: rtl/gf_pow_seq.sv
// gf_pow_seq: r = base^exponent in GF(2^W), left-to-right square-and-multiply over a shared datapath.
// Latency: (W + popcount(exponent))*(W+1) + 1 cycles from accepted start to the done pulse.
// No backpressure: start is accepted only in IDLE and outside the done cycle; other starts are dropped.
module gf_pow_seq #(
   parameter int DATA_WIDTH = 32,
   parameter bit CARRY_OPT  = 1'b0
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [DATA_WIDTH-1:0]     base,
   input  logic [DATA_WIDTH-1:0]     exponent,
   input  logic [DATA_WIDTH-1:0]     poly,
   output logic                      busy,
   output logic                      done,
   output logic [DATA_WIDTH-1:0]     result,
   output logic [DATA_WIDTH-1:0]     dp_a,
   output logic [DATA_WIDTH-1:0]     dp_b,
   output logic                      dp_sum_funct,
   output logic                      dp_exp_funct,
   output logic                      dp_carry_option,
   input  logic [2*DATA_WIDTH-1:0]   dp_mult_out
);

   localparam int W  = DATA_WIDTH;
   // Counter width: holds W-1 for both the exponent bit index and the reduction counter.
   localparam int CW = $clog2(W);
   // Width needed to address one bit of the 2W-bit product.
   localparam int PW = $clog2(2 * W);

   typedef enum logic [2:0] {
      S_IDLE,
      S_MUL,
      S_RED,
      S_STEP,
      S_DONE
   } state_t;

   typedef enum logic {
      OP_SQR,
      OP_MULB
   } op_t;

   state_t              state;
   op_t                 op;
   logic [W-1:0]        base_q;
   logic [W-1:0]        exp_q;
   logic [W-1:0]        poly_q;
   logic [W-1:0]        r;
   logic [2*W-1:0]      prod;
   logic [CW-1:0]       idx;
   logic [CW-1:0]       cnt;

   logic [PW-1:0]       red_j;
   logic                red_bit;
   logic [2*W-1:0]      red_mask;

   // Reduction step: examine product bit j = W+cnt-1 and, if set, cancel it with the
   // full modulus (x^W implicit) aligned so its leading term lands on bit j.
   always_comb begin
      red_j    = PW'(W - 1) + PW'(cnt);
      red_bit  = prod[red_j];
      red_mask = {{(W-1){1'b0}}, 1'b1, poly_q} << (cnt - CW'(1));
   end

   // Datapath operands are only presented while multiplying; zero otherwise so the
   // shared multiplier sees quiet inputs between operations.
   assign dp_a            = (state == S_MUL) ? r : '0;
   assign dp_b            = (state == S_MUL) ? ((op == OP_SQR) ? r : base_q) : '0;
   assign dp_sum_funct    = 1'b0;
   assign dp_exp_funct    = 1'b0;
   assign dp_carry_option = CARRY_OPT;

   // Sequencer: one square (and optionally one multiply-by-base) per exponent bit,
   // MSB first; every product is captured in MUL and reduced bit-serially in RED.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= S_IDLE;
         op     <= OP_SQR;
         busy   <= 1'b0;
         done   <= 1'b0;
         result <= '0;
         base_q <= '0;
         exp_q  <= '0;
         poly_q <= '0;
         r      <= '0;
         prod   <= '0;
         idx    <= '0;
         cnt    <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               // A start coinciding with the done pulse belongs to the finishing
               // request's window and is dropped.
               if (start && !done) begin
                  base_q <= base;
                  exp_q  <= exponent;
                  poly_q <= poly;
                  r      <= {{(W-1){1'b0}}, 1'b1};
                  idx    <= CW'(W - 1);
                  op     <= OP_SQR;
                  busy   <= 1'b1;
                  state  <= S_MUL;
               end
            end
            S_MUL: begin
               prod  <= dp_mult_out;
               cnt   <= CW'(W - 1);
               state <= S_RED;
            end
            S_RED: begin
               // Fixed W-1 cycles whether or not a bit is set, keeping latency data-independent.
               if (red_bit) begin
                  prod <= prod ^ red_mask;
               end
               cnt <= cnt - CW'(1);
               if (cnt == CW'(1)) begin
                  state <= S_STEP;
               end
            end
            S_STEP: begin
               r <= prod[W-1:0];
               if (op == OP_SQR && exp_q[idx]) begin
                  op    <= OP_MULB;
                  state <= S_MUL;
               end else if (idx == '0) begin
                  state <= S_DONE;
               end else begin
                  idx   <= idx - CW'(1);
                  op    <= OP_SQR;
                  state <= S_MUL;
               end
            end
            S_DONE: begin
               result <= r;
               done   <= 1'b1;
               busy   <= 1'b0;
               state  <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gf_pow_seq.sv
// Directed bench for gf_pow_seq at W=8 with the AES modulus 0x11B.
// A combinational carry-less multiplier stands in for the shared datapath.
// Expected results and latencies are hand-computed constants.
module tb_gf_pow_seq;

   localparam int W = 8;

   logic           clk = 1'b0;
   logic           rst;
   logic           start;
   logic [W-1:0]   base;
   logic [W-1:0]   exponent;
   logic [W-1:0]   poly;
   logic           busy;
   logic           done;
   logic [W-1:0]   result;
   logic [W-1:0]   dp_a;
   logic [W-1:0]   dp_b;
   logic           dp_sum_funct;
   logic           dp_exp_funct;
   logic           dp_carry_option;
   logic [2*W-1:0] dp_mult_out;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   gf_pow_seq #(.DATA_WIDTH(W), .CARRY_OPT(1'b0)) dut (
      .clk             (clk),
      .rst             (rst),
      .start           (start),
      .base            (base),
      .exponent        (exponent),
      .poly            (poly),
      .busy            (busy),
      .done            (done),
      .result          (result),
      .dp_a            (dp_a),
      .dp_b            (dp_b),
      .dp_sum_funct    (dp_sum_funct),
      .dp_exp_funct    (dp_exp_funct),
      .dp_carry_option (dp_carry_option),
      .dp_mult_out     (dp_mult_out)
   );

   // Carry-less product, the datapath the sequencer expects to drive.
   function automatic logic [15:0] clmul(input logic [7:0] a, input logic [7:0] b);
      logic [15:0] acc;
      acc = '0;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) acc = acc ^ (16'(a) << i);
      end
      return acc;
   endfunction

   // Full AES-field multiply, used only to confirm an inverse.
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [15:0] p;
      p = clmul(a, b);
      for (int i = 14; i >= 8; i--) begin
         if (p[i]) p = p ^ (16'h011B << (i - 8));
      end
      return p[7:0];
   endfunction

   assign dp_mult_out = clmul(dp_a, dp_b);

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // One exponentiation. restart_at >= 0 pulses a second start mid-run;
   // rst_at >= 0 aborts the run with a reset at that cycle.
   task automatic run(input string tag, input logic [7:0] b, input logic [7:0] e,
                      input logic [7:0] exp_res, input int restart_at, input int rst_at);
      int   ops;
      int   lat;
      int   dp_bad;
      int   both_bad;
      int   tie_bad;
      int   stray;
      bit   aborted;
      logic mul_phase;
      ops      = 8 + $countones(e);
      lat      = -1;
      dp_bad   = 0;
      both_bad = 0;
      tie_bad  = 0;
      stray    = 0;
      aborted  = 1'b0;
      @(negedge clk);
      base     = b;
      exponent = e;
      poly     = 8'h1B;
      start    = 1'b1;
      for (int p = 0; p < 400; p++) begin
         @(negedge clk);
         if (p == 0) begin
            start    = 1'b0;
            base     = ~b;
            exponent = ~e;
            poly     = 8'hA5;
            check({tag, "/busy_after_start"}, 32'(busy), 32'd1);
         end
         if (p == restart_at) begin
            start    = 1'b1;
            exponent = 8'hFF;
            base     = 8'h07;
         end
         if (p == restart_at + 1) start = 1'b0;
         if (busy && done) both_bad++;
         if (dp_sum_funct !== 1'b0 || dp_exp_funct !== 1'b0 || dp_carry_option !== 1'b0) tie_bad++;
         mul_phase = ((p % 9) == 0) && (p < ops * 9);
         if (!mul_phase && (dp_a !== 8'h00 || dp_b !== 8'h00)) dp_bad++;
         if (p == rst_at) begin
            rst = 1'b1;
            @(negedge clk);
            check({tag, "/rst_busy"},   32'(busy),   32'd0);
            check({tag, "/rst_done"},   32'(done),   32'd0);
            check({tag, "/rst_result"}, 32'(result), 32'd0);
            check({tag, "/rst_dp_a"},   32'(dp_a),   32'd0);
            check({tag, "/rst_dp_b"},   32'(dp_b),   32'd0);
            rst = 1'b0;
            for (int k = 0; k < ops * 9 + 20; k++) begin
               @(negedge clk);
               if (done || busy) stray++;
            end
            check({tag, "/no_activity_after_rst"}, 32'(stray), 32'd0);
            aborted = 1'b1;
            break;
         end
         if (done) begin
            lat = p;
            break;
         end
      end
      if (!aborted) begin
         check({tag, "/result"},  32'(result), 32'(exp_res));
         check({tag, "/latency"}, 32'(lat),    32'(ops * 9 + 1));
         // start presented in the done cycle must be ignored
         start    = 1'b1;
         base     = 8'h55;
         exponent = 8'h01;
         @(negedge clk);
         start = 1'b0;
         check({tag, "/start_at_done_ignored"}, 32'(busy), 32'd0);
         check({tag, "/result_held"}, 32'(result), 32'(exp_res));
      end
      check({tag, "/dp_zero_outside_mul"}, 32'(dp_bad),   32'd0);
      check({tag, "/busy_done_exclusive"}, 32'(both_bad), 32'd0);
      check({tag, "/tied_controls"},       32'(tie_bad),  32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      rst      = 1'b1;
      start    = 1'b0;
      base     = '0;
      exponent = '0;
      poly     = '0;
      repeat (3) @(negedge clk);
      check("reset/busy",   32'(busy),   32'd0);
      check("reset/done",   32'(done),   32'd0);
      check("reset/result", 32'(result), 32'd0);
      check("reset/dp_a",   32'(dp_a),   32'd0);
      check("reset/dp_b",   32'(dp_b),   32'd0);
      rst = 1'b0;
      @(negedge clk);

      run("sq3",      8'h03, 8'h02, 8'h05, -1, -1);
      run("inv03",    8'h03, 8'hFE, 8'hF6, -1, -1);
      run("inv53",    8'h53, 8'hFE, 8'hCA, -1, -1);
      check("inv53/product_is_one", 32'(gf_mul(8'h53, result)), 32'd1);
      run("zero_e0",  8'h00, 8'h00, 8'h01, -1, -1);
      run("zero_e5",  8'h00, 8'h05, 8'h00, -1, -1);
      run("x_pow8",   8'h02, 8'h08, 8'h1B, -1, -1);
      run("sq80",     8'h80, 8'h02, 8'h9A, -1, -1);
      run("one_e3",   8'h01, 8'h03, 8'h01, -1, -1);
      // 0x02 has multiplicative order 51 under 0x11B, so x^0x33 = 1
      run("restart",  8'h02, 8'h33, 8'h01, 20, -1);
      run("abort",    8'h03, 8'h02, 8'h05, -1, 40);
      run("after_rst", 8'h03, 8'h02, 8'h05, -1, -1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
